// File: rtl/dsrlzr_sipo.sv
// Serial-in parallel-out deserializer: rebuilds WIDTH-bit words from a 1-bit
// stream aligned by a sync strobe, with a valid/ready output and overrun flag.
module dsrlzr_sipo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ser_in,
    input  logic           ser_en,
    input  logic           sync,
    input  logic           ready,
    output logic [1:WIDTH] y,
    output logic           valid,
    output logic           overrun,
    output logic           busy
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:WIDTH]   r_sh;
    logic [1:WIDTH]   r_y;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic             r_overrun;
    logic             r_busy;

    logic [1:WIDTH]   w_shifted;
    logic [1:WIDTH]   w_sh_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_complete;
    logic             w_xfer;

    // sync outranks completion: a sync on the would-be last bit starts a new word
    always_comb begin
        w_shifted  = {r_sh[2:WIDTH], ser_in};
        w_xfer     = r_valid & ready;
        w_complete = ser_en & ~sync & (r_cnt == LAST_BIT);
        w_sh_next  = r_sh;
        w_cnt_next = r_cnt;
        if (ser_en && sync) begin
            w_sh_next        = '0;
            w_sh_next[WIDTH] = ser_in;
            w_cnt_next       = CNT_W'(1);
        end else if (ser_en) begin
            w_sh_next  = w_shifted;
            w_cnt_next = w_complete ? '0 : r_cnt + CNT_W'(1);
        end else if (sync) begin
            w_sh_next  = '0;
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh      <= '0;
            r_y       <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_sh      <= w_sh_next;
            r_cnt     <= w_cnt_next;
            r_busy    <= (w_cnt_next != '0);
            r_overrun <= w_complete & r_valid & ~ready;
            if (w_complete) begin
                // a held, unaccepted word wins; the new one is dropped
                if (!r_valid || ready) begin
                    r_y     <= w_shifted;
                    r_valid <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign y       = r_y;
    assign valid   = r_valid;
    assign overrun = r_overrun;
    assign busy    = r_busy;

endmodule

// File: tb/tb_dsrlzr_sipo.sv
// Directed bench for dsrlzr_sipo: expected words go into a scoreboard queue,
// a negedge monitor pops and compares them on every accepted transfer.
module tb_dsrlzr_sipo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser_in;
    logic       ser_en;
    logic       sync;
    logic       ready;
    logic [1:4] y;
    logic       valid;
    logic       overrun;
    logic       busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [3:0]  exp_q[$];

    dsrlzr_sipo #(.WIDTH(4), .CNT_W(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ser_in  (ser_in),
        .ser_en  (ser_en),
        .sync    (sync),
        .ready   (ready),
        .y       (y),
        .valid   (valid),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge when valid && ready here
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got %0h expected none at %0t", y, $time);
            end else begin
                chk("xfer_word", 32'(y), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; returns 1 time unit after the rising edge
    task automatic drive(input logic en, input logic sy, input logic b, input logic rdy);
        ser_en = en;
        sync   = sy;
        ser_in = b;
        ready  = rdy;
        @(posedge clk);
        #1;
        ser_en = 1'b0;
        sync   = 1'b0;
        ser_in = 1'b0;
        ready  = 1'b0;
    endtask

    // First bit of w (w[3]) is sent first and lands in y[1]
    task automatic send_word(input logic [3:0] w, input logic sy, input logic last_rdy);
        for (int i = 0; i < 4; i++)
            drive(1'b1, sy && (i == 0), w[3-i], (i == 3) ? last_rdy : 1'b0);
    endtask

    task automatic accept();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        ser_in = 1'b0;
        ser_en = 1'b0;
        sync   = 1'b0;
        ready  = 1'b0;
        #3;
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: reset mid-word
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_busy_partial", 32'(busy), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_async_y", 32'(y), 32'h0);
        chk("t1_async_valid", 32'(valid), 32'h0);
        chk("t1_async_busy", 32'(busy), 32'h0);
        #1 rst_n = 1'b1;
        send_word(4'b1100, 1'b0, 1'b0);
        chk("t1_valid", 32'(valid), 32'h1);
        chk("t1_y", 32'(y), 32'hC);
        exp_q.push_back(4'b1100);
        accept();
        chk("t1_valid_clr", 32'(valid), 32'h0);

        // 2: basic frame
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t2_busy", 32'(busy), 32'h1);
        chk("t2_valid_early", 32'(valid), 32'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t2_y", 32'(y), 32'hB);
        chk("t2_valid", 32'(valid), 32'h1);
        chk("t2_busy_done", 32'(busy), 32'h0);
        exp_q.push_back(4'b1011);
        accept();
        chk("t2_valid_clr", 32'(valid), 32'h0);
        chk("t2_y_hold", 32'(y), 32'hB);

        // 3: gapped input
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, (4'b0110 >> (3 - i)) & 1'b1, 1'b0);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) drive(1'b0, 1'b0, 1'b1, 1'b0);
                chk("t3_valid_gap", 32'(valid), 32'h0);
                chk("t3_busy_gap", 32'(busy), 32'h1);
            end
        end
        chk("t3_y", 32'(y), 32'h6);
        chk("t3_valid", 32'(valid), 32'h1);
        exp_q.push_back(4'b0110);
        accept();

        // 4: overrun
        send_word(4'b1011, 1'b1, 1'b0);
        exp_q.push_back(4'b1011);
        chk("t4_ovr_quiet", 32'(overrun), 32'h0);
        send_word(4'b0101, 1'b1, 1'b0);
        chk("t4_overrun", 32'(overrun), 32'h1);
        chk("t4_y_kept", 32'(y), 32'hB);
        chk("t4_valid", 32'(valid), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_ovr_pulse", 32'(overrun), 32'h0);
        chk("t4_y_stable", 32'(y), 32'hB);

        // 5: simultaneous accept and completion
        send_word(4'b0101, 1'b1, 1'b1);
        chk("t5_y", 32'(y), 32'h5);
        chk("t5_valid", 32'(valid), 32'h1);
        chk("t5_overrun", 32'(overrun), 32'h0);
        exp_q.push_back(4'b0101);
        accept();

        // 6: resync discards partial bits
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_busy", 32'(busy), 32'h1);
        chk("t6_no_word", 32'(valid), 32'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t6_y", 32'(y), 32'h5);
        chk("t6_valid", 32'(valid), 32'h1);
        exp_q.push_back(4'b0101);
        accept();

        // 7: sync on the would-be completing edge produces no word
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t7_no_word", 32'(valid), 32'h0);
        chk("t7_busy", 32'(busy), 32'h1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t7_y", 32'(y), 32'h6);
        exp_q.push_back(4'b0110);
        accept();

        // 8: sync without ser_en clears the partial word
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t8_busy_clr", 32'(busy), 32'h0);
        send_word(4'b0011, 1'b0, 1'b0);
        chk("t8_y", 32'(y), 32'h3);
        chk("t8_valid", 32'(valid), 32'h1);
        exp_q.push_back(4'b0011);
        accept();

        chk("end_valid", 32'(valid), 32'h0);
        chk("end_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dsrlzr_sipo.md
Name: dsrlzr_sipo

Overview:
- Receive-side counterpart of the transceiver serializer: converts a 1-bit serial stream back into WIDTH-bit parallel words.
- Sits after the serial link in the Transceiver path.
- Frames are aligned by a sync strobe. Completed words are presented on a valid/ready output with overrun detection.
- Bit order matches the serializer: the first serial bit received lands in y[1], the last in y[WIDTH].

Parameters:
- WIDTH, 4, word length in bits (>= 2).
- CNT_W, 2, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- ser_in, input, 1, serial data bit.
- ser_en, input, 1, ser_in is sampled only on edges where ser_en=1.
- sync, input, 1, frame alignment strobe; marks ser_in as bit 1 of a new word.
- ready, input, 1, downstream accepts the word on y when valid=1.
- y, output, [1:WIDTH], received parallel word.
- valid, output, 1, y holds an unconsumed word.
- overrun, output, 1, one-cycle pulse: a completed word was dropped.
- busy, output, 1, a partial word is in progress (bit count != 0).

Behaviour:
- Reset: asynchronous, active-low (rst_n=0). Clears the shift register, bit count, y, valid, overrun and busy to 0 immediately, independent of clk. Any partial word is lost. Operation resumes on the first rising edge after rst_n=1.
- Internal state: shift register sh[1:WIDTH]; bit counter cnt (0..WIDTH-1). FSM is implied by cnt: cnt=0 is IDLE/HUNT, cnt>0 is SHIFT.
- Sampling, on an edge with ser_en=1:
  - sh <= {sh[2:WIDTH], ser_in}.
  - cnt <= cnt+1.
- sync=1 with ser_en=1:
  - Previous partial bits are discarded.
  - ser_in becomes bit 1: sh cleared except the newest bit; cnt <= 1.
  - If WIDTH bits would complete on the same edge, sync takes priority and no word is produced.
- sync=1 with ser_en=0: cnt <= 0 and the partial word is discarded.
- ser_en=0 and sync=0: shift register and cnt hold. Gaps of any length are allowed.
- Word completion: an edge with ser_en=1, sync=0 and cnt=WIDTH-1. The completed word is {sh[2:WIDTH], ser_in}, and cnt wraps to 0. Latency is 0 cycles: y and valid update on that same edge.
- Output handshake:
  - Transfer occurs on an edge where valid=1 and ready=1.
  - Completion with valid=0: y <= word, valid <= 1.
  - Completion with valid=1 and ready=1 on the same edge: y <= new word, valid stays 1, no overrun.
  - Completion with valid=1 and ready=0: new word dropped; y and valid unchanged; overrun=1 for exactly that cycle.
  - Transfer without completion: valid <= 0; y holds its last value.
  - ready is ignored while valid=0.
- y is stable while valid=1 and ready=0.
- overrun is otherwise 0. It is registered (asserted after the offending edge).
- busy = (cnt != 0), registered.
- Before the first sync, counting starts from the post-reset cnt=0, so the first WIDTH enabled bits form a word.

Test Plan:
1. Reset mid-word: drive sync+2 bits, then pulse rst_n=0 between clock edges -> y=0000, valid=0, busy=0 immediately. Next 4 enabled bits 1,1,0,0 -> y=1100.
2. Basic frame: ser_en=1 continuous, sync on first bit, bits 1,0,1,1, ready=0 -> on 4th edge y=1011, valid=1, busy=0. Then ready=1 for one edge -> valid=0.
3. Gapped input: bits 0,1,1,0 with ser_en low for 3 cycles between each -> y=0110, valid=1 only after the 4th enabled edge.
4. Overrun: word 1011 completes, ready held 0, next word 0101 completes -> overrun=1 for one cycle; y stays 1011; valid=1.
5. Simultaneous accept: valid=1 with y=1011, ready=1 on the edge completing 0101 -> y=0101, valid=1, overrun=0.
6. Resync: bits 1,1 then sync with ser_in=0, followed by 1,0,1 -> partial discarded, y=0101, no extra word produced.
